// File: rtl/gpio_bridge_pkg.sv
// Shared definitions for the GPIO bus bridge: FSM encoding, default
// address window and the pattern returned for a decode-error read.
package gpio_bridge_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } bridge_state_t;

   localparam logic [31:0] GPIO_BASE_ADDR_DEF = 32'h4000_0000;
   localparam logic [31:0] GPIO_ADDR_MASK_DEF = 32'hFFFF_FFF0;
   localparam logic [31:0] GPIO_ERR_PATTERN   = 32'hDEAD_BEEF;

endpackage

// File: rtl/gpio_addr_decode.sv
// Combinational window decode: word-aligned address inside BASE_ADDR/ADDR_MASK.
module gpio_addr_decode
   import gpio_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = GPIO_BASE_ADDR_DEF,
   parameter logic [31:0] ADDR_MASK = GPIO_ADDR_MASK_DEF
) (
   input  logic [31:0] addr,
   output logic        hit
);

   assign hit = ((addr & ADDR_MASK) == BASE_ADDR) && (addr[1:0] == 2'b00);

endmodule

// File: rtl/gpio_bus_bridge.sv
// Single-outstanding valid/ready to GPIO strobe bridge with fixed read latency.
// Optional decode-error reporting is enabled by defining GPIO_BRIDGE_ERR_EN.
module gpio_bus_bridge
   import gpio_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = GPIO_BASE_ADDR_DEF,
   parameter logic [31:0] ADDR_MASK = GPIO_ADDR_MASK_DEF,
   parameter int unsigned READ_LAT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        sel,
   output logic        write_en,
   output logic        read_en,
   output logic [31:0] wdata,
   input  logic [31:0] rdata
);

   bridge_state_t state;
   logic          we_q;
   logic [2:0]    wait_cnt;
   logic          addr_hit;
   logic          accept;
   logic [31:0]   miss_rdata;

   gpio_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .ADDR_MASK (ADDR_MASK)
   ) u_addr_decode (
      .addr (req_addr),
      .hit  (addr_hit)
   );

   assign accept = req_valid && req_ready;

`ifdef GPIO_BRIDGE_ERR_EN
   logic err_q;

   // Error flag is decided at accept time and held through RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state == S_IDLE && accept) begin
         err_q <= ~addr_hit;
      end
   end

   assign rsp_err    = err_q;
   assign miss_rdata = req_we ? 32'h0 : GPIO_ERR_PATTERN;
`else
   assign rsp_err    = 1'b0;
   assign miss_rdata = 32'h0;
`endif

   // All bus-facing outputs are registered; each branch sets the values
   // that belong to the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         sel       <= 1'b0;
         write_en  <= 1'b0;
         read_en   <= 1'b0;
         wdata     <= 32'h0;
         we_q      <= 1'b0;
         wait_cnt  <= 3'd0;
      end else begin
         write_en <= 1'b0;
         read_en  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  we_q      <= req_we;
                  wdata     <= req_wdata;
                  if (addr_hit) begin
                     state    <= S_ACCESS;
                     sel      <= 1'b1;
                     write_en <= req_we;
                     read_en  <= ~req_we;
                     if (req_we) begin
                        rsp_rdata <= 32'h0;
                     end
                  end else begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= miss_rdata;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            S_ACCESS: begin
               if (we_q) begin
                  state     <= S_RESP;
                  sel       <= 1'b0;
                  rsp_valid <= 1'b1;
               end else begin
                  state    <= S_WAIT;
                  wait_cnt <= 3'(READ_LAT - 1);
               end
            end
            S_WAIT: begin
               if (wait_cnt == 3'd0) begin
                  state     <= S_RESP;
                  sel       <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rdata;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               sel       <= 1'b0;
               rsp_valid <= 1'b0;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
